// File: rtl/ex_stage_pkg.sv
// Shared widths, opcodes, result classes and divider state encodings for the execute stage.
package ex_stage_pkg;

  localparam int unsigned REG_W          = 32;
  localparam int unsigned REG_ADDR_W     = 5;
  localparam int unsigned ALUOP_W        = 8;
  localparam int unsigned ALUSEL_W       = 3;
  localparam int unsigned SHAMT_W        = 5;
  localparam int unsigned DIV_STEPS_DFLT = 32;

  // Operation codes
  localparam logic [ALUOP_W-1:0] EXE_NOP_OP   = 8'h00;
  localparam logic [ALUOP_W-1:0] EXE_AND_OP   = 8'h24;
  localparam logic [ALUOP_W-1:0] EXE_OR_OP    = 8'h25;
  localparam logic [ALUOP_W-1:0] EXE_XOR_OP   = 8'h26;
  localparam logic [ALUOP_W-1:0] EXE_NOT_OP   = 8'h27;
  localparam logic [ALUOP_W-1:0] EXE_SHL_OP   = 8'h7c;
  localparam logic [ALUOP_W-1:0] EXE_SHR_OP   = 8'h02;
  localparam logic [ALUOP_W-1:0] EXE_SAR_OP   = 8'h03;
  localparam logic [ALUOP_W-1:0] EXE_MOVZ_OP  = 8'h0a;
  localparam logic [ALUOP_W-1:0] EXE_MOVN_OP  = 8'h0b;
  localparam logic [ALUOP_W-1:0] EXE_MOV_OP   = 8'h0c;
  localparam logic [ALUOP_W-1:0] EXE_MULT_OP  = 8'h18;
  localparam logic [ALUOP_W-1:0] EXE_MULTU_OP = 8'h19;
  localparam logic [ALUOP_W-1:0] EXE_DIV_OP   = 8'h1a;
  localparam logic [ALUOP_W-1:0] EXE_DIVU_OP  = 8'h1b;
  localparam logic [ALUOP_W-1:0] EXE_ADD_OP   = 8'h20;
  localparam logic [ALUOP_W-1:0] EXE_SUB_OP   = 8'h22;

  // Result classes
  localparam logic [ALUSEL_W-1:0] EXE_RES_NOP   = 3'd0;
  localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC = 3'd1;
  localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT = 3'd2;
  localparam logic [ALUSEL_W-1:0] EXE_RES_MOVE  = 3'd3;
  localparam logic [ALUSEL_W-1:0] EXE_RES_ARITH = 3'd4;

  // Divider states
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  // HI/LO payload; for a divide hi is the remainder and lo the quotient
  typedef struct packed {
    logic [REG_W-1:0] hi;
    logic [REG_W-1:0] lo;
  } hilo_t;

  function automatic logic is_div_op(input logic [ALUOP_W-1:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/ex_stage_div_seq.sv
// Iterative restoring divider: one quotient bit per cycle on operand magnitudes, sign fix-up at the end.
module div_seq
  import ex_stage_pkg::*;
#(
  parameter int unsigned DIV_STEPS = DIV_STEPS_DFLT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             annul_i,
  input  logic [REG_W-1:0] opdata1_i,
  input  logic [REG_W-1:0] opdata2_i,
  output logic             ready_o,
  output hilo_t            result_o,
  output logic             stall_c
);

  localparam int unsigned CNT_W = $clog2(DIV_STEPS);
  localparam int unsigned ACC_W = 2 * REG_W + 1;

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [REG_W-1:0]   divisor_q, divisor_d;
  logic [REG_W-1:0]   dividend_q, dividend_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  hilo_t              result_q, result_d;

  logic [ACC_W-1:0]   shifted;
  logic [REG_W:0]     diff;
  logic               fits;
  logic [ACC_W-1:0]   acc_step;
  logic [REG_W-1:0]   quo_abs;
  logic [REG_W-1:0]   rem_abs;
  logic [REG_W-1:0]   op1_abs;
  logic [REG_W-1:0]   op2_abs;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= DIV_FREE;
      cnt_q      <= '0;
      acc_q      <= '0;
      divisor_q  <= '0;
      dividend_q <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      divisor_q  <= divisor_d;
      dividend_q <= dividend_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      result_q   <= result_d;
    end
  end

  // Next state, restoring step and stall request
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    divisor_d  = divisor_q;
    dividend_d = dividend_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    result_d   = result_q;
    stall_c    = 1'b0;

    // Partial remainder stays below the divisor, so after the shift it fits in REG_W+1 bits
    shifted  = {acc_q[ACC_W-2:0], 1'b0};
    fits     = shifted[ACC_W-1:REG_W] >= {1'b0, divisor_q};
    diff     = shifted[ACC_W-1:REG_W] - {1'b0, divisor_q};
    acc_step = fits ? {diff, shifted[REG_W-1:1], 1'b1} : shifted;
    quo_abs  = acc_step[REG_W-1:0];
    rem_abs  = acc_step[2*REG_W-1:REG_W];

    // Magnitude of 0x80000000 is itself as an unsigned value, which covers -2^31 / -1
    op1_abs = (signed_i && opdata1_i[REG_W-1]) ? (~opdata1_i + REG_W'(1)) : opdata1_i;
    op2_abs = (signed_i && opdata2_i[REG_W-1]) ? (~opdata2_i + REG_W'(1)) : opdata2_i;

    if (annul_i) begin
      state_d = DIV_FREE;
    end else begin
      case (state_q)
        DIV_FREE: begin
          if (start_i) begin
            stall_c    = 1'b1;
            dividend_d = opdata1_i;
            divisor_d  = op2_abs;
            acc_d      = {{(REG_W + 1){1'b0}}, op1_abs};
            cnt_d      = '0;
            q_neg_d    = signed_i && (opdata1_i[REG_W-1] ^ opdata2_i[REG_W-1]);
            r_neg_d    = signed_i && opdata1_i[REG_W-1];
            state_d    = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
          end
        end
        DIV_BY_ZERO: begin
          stall_c     = 1'b1;
          result_d.hi = dividend_q;
          result_d.lo = '1;
          state_d     = DIV_END;
        end
        DIV_ON: begin
          stall_c = 1'b1;
          acc_d   = acc_step;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DIV_STEPS - 1)) begin
            result_d.lo = q_neg_q ? (~quo_abs + REG_W'(1)) : quo_abs;
            result_d.hi = r_neg_q ? (~rem_abs + REG_W'(1)) : rem_abs;
            state_d     = DIV_END;
          end
        end
        DIV_END: begin
          // Inputs still show the divide here; returning to FREE without restarting
          state_d = DIV_FREE;
        end
        default: state_d = DIV_FREE;
      endcase
    end
  end

  assign ready_o  = (state_q == DIV_END);
  assign result_o = result_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU and multiply, iterative divide with pipeline stall.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int unsigned DIV_STEPS = DIV_STEPS_DFLT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ALUOP_W-1:0]    aluop_i,
  input  logic [ALUSEL_W-1:0]   alusel_i,
  input  logic [REG_W-1:0]      reg1_i,
  input  logic [REG_W-1:0]      reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic                  flush_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [REG_W-1:0]      wdata_o,
  output logic [REG_W-1:0]      hi_o,
  output logic [REG_W-1:0]      lo_o,
  output logic                  whilo_o,
  output logic                  stallreq_o
);

  logic              div_start;
  logic              div_signed;
  logic              div_ready;
  logic              div_stall_c;
  hilo_t             div_result;
  logic [REG_W-1:0]  alu_c;
  logic [2*REG_W-1:0] prod_s;
  logic [2*REG_W-1:0] prod_u;

  assign div_start  = is_div_op(aluop_i);
  assign div_signed = (aluop_i == EXE_DIV_OP);

  div_seq #(
    .DIV_STEPS (DIV_STEPS)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start_i   (div_start),
    .signed_i  (div_signed),
    .annul_i   (flush_i),
    .opdata1_i (reg1_i),
    .opdata2_i (reg2_i),
    .ready_o   (div_ready),
    .result_o  (div_result),
    .stall_c   (div_stall_c)
  );

  // Full-width products, operands extended to 64 bits before multiplying
  assign prod_s = $signed({{REG_W{reg1_i[REG_W-1]}}, reg1_i}) *
                  $signed({{REG_W{reg2_i[REG_W-1]}}, reg2_i});
  assign prod_u = {{REG_W{1'b0}}, reg1_i} * {{REG_W{1'b0}}, reg2_i};

  // GPR result selected by result class, then by operation
  always_comb begin
    alu_c = '0;
    case (alusel_i)
      EXE_RES_LOGIC: begin
        case (aluop_i)
          EXE_OR_OP:  alu_c = reg1_i | reg2_i;
          EXE_AND_OP: alu_c = reg1_i & reg2_i;
          EXE_XOR_OP: alu_c = reg1_i ^ reg2_i;
          EXE_NOT_OP: alu_c = ~reg1_i;
          default:    alu_c = '0;
        endcase
      end
      EXE_RES_SHIFT: begin
        case (aluop_i)
          EXE_SHL_OP: alu_c = reg1_i << reg2_i[SHAMT_W-1:0];
          EXE_SHR_OP: alu_c = reg1_i >> reg2_i[SHAMT_W-1:0];
          EXE_SAR_OP: alu_c = REG_W'($signed(reg1_i) >>> reg2_i[SHAMT_W-1:0]);
          default:    alu_c = '0;
        endcase
      end
      EXE_RES_MOVE: begin
        case (aluop_i)
          EXE_MOV_OP:  alu_c = reg1_i;
          EXE_MOVZ_OP: alu_c = reg2_i;
          EXE_MOVN_OP: alu_c = reg2_i;
          default:     alu_c = '0;
        endcase
      end
      EXE_RES_ARITH: begin
        case (aluop_i)
          EXE_ADD_OP: alu_c = reg1_i + reg2_i;
          EXE_SUB_OP: alu_c = reg1_i - reg2_i;
          default:    alu_c = '0;
        endcase
      end
      default: alu_c = '0;
    endcase
  end

  // Output mux; every output held at zero while reset is asserted
  always_comb begin
    wd_o       = '0;
    wreg_o     = 1'b0;
    wdata_o    = '0;
    hi_o       = '0;
    lo_o       = '0;
    whilo_o    = 1'b0;
    stallreq_o = 1'b0;
    if (rst) begin
      wd_o       = wd_i;
      wreg_o     = wreg_i;
      wdata_o    = alu_c;
      stallreq_o = div_stall_c;
      if (aluop_i == EXE_MULT_OP) begin
        {hi_o, lo_o} = prod_s;
        whilo_o      = 1'b1;
      end else if (aluop_i == EXE_MULTU_OP) begin
        {hi_o, lo_o} = prod_u;
        whilo_o      = 1'b1;
      end else if (div_start && div_ready && !flush_i) begin
        hi_o    = div_result.hi;
        lo_o    = div_result.lo;
        whilo_o = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Randomised and directed bench for ex_stage against a behavioural arithmetic model.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i, reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic        flush_i = 1'b0;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o, hi_o, lo_o;
  logic        whilo_o, stallreq_o;

  int checks   = 0;
  int failures = 0;
  int div_left = 0;  // cycles until the in-flight divide reports (1 = result cycle)

  ex_stage dut (
    .clk        (clk),
    .rst        (rst),
    .aluop_i    (aluop_i),
    .alusel_i   (alusel_i),
    .reg1_i     (reg1_i),
    .reg2_i     (reg2_i),
    .wd_i       (wd_i),
    .wreg_i     (wreg_i),
    .flush_i    (flush_i),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .whilo_o    (whilo_o),
    .stallreq_o (stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Arithmetic view of each operation
  function automatic logic [31:0] exp_alu(input logic [2:0] sel, input logic [7:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
    longint p, sa;
    p  = longint'(1) << b[4:0];
    sa = longint'($signed(a));
    if (sel == EXE_RES_LOGIC) begin
      if (op == EXE_OR_OP)  return a | b;
      if (op == EXE_AND_OP) return a & b;
      if (op == EXE_XOR_OP) return a ^ b;
      if (op == EXE_NOT_OP) return 32'hFFFF_FFFF - a;
    end else if (sel == EXE_RES_SHIFT) begin
      if (op == EXE_SHL_OP) return 32'(longint'(a) * p);
      if (op == EXE_SHR_OP) return 32'(longint'(a) / p);
      if (op == EXE_SAR_OP) return (sa >= 0) ? 32'(sa / p) : 32'(-((-sa + p - 1) / p));
    end else if (sel == EXE_RES_MOVE) begin
      if (op == EXE_MOV_OP) return a;
      if (op == EXE_MOVZ_OP || op == EXE_MOVN_OP) return b;
    end else if (sel == EXE_RES_ARITH) begin
      if (op == EXE_ADD_OP) return 32'(longint'(a) + longint'(b));
      if (op == EXE_SUB_OP) return 32'(longint'(a) - longint'(b));
    end
    return 32'h0;
  endfunction

  function automatic logic [63:0] exp_mul(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = 64'(a);
    ub = 64'(b);
    return ua * ub;
  endfunction

  // {remainder, quotient}
  function automatic logic [63:0] exp_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      sa = $signed(a);
      sb = $signed(b);
      return {32'(sa % sb), 32'(sa / sb)};
    end
    return {a % b, a / b};
  endfunction

  // Divide progress tracked as remaining latency
  always @(posedge clk) begin
    if (!rst || flush_i) div_left <= 0;
    else if (div_left > 0) div_left <= div_left - 1;
    else if (aluop_i == EXE_DIV_OP || aluop_i == EXE_DIVU_OP) div_left <= (reg2_i == 32'h0) ? 2 : 33;
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin : compare
    logic [31:0] e_wdata, e_hi, e_lo;
    logic [4:0]  e_wd;
    logic        e_wreg, e_whilo, e_stall;
    logic [63:0] hl;
    e_wdata = 32'h0; e_hi = 32'h0; e_lo = 32'h0; e_wd = 5'h0;
    e_wreg = 1'b0; e_whilo = 1'b0; e_stall = 1'b0;
    if (rst) begin
      e_wd    = wd_i;
      e_wreg  = wreg_i;
      e_wdata = exp_alu(alusel_i, aluop_i, reg1_i, reg2_i);
      if (aluop_i == EXE_MULT_OP || aluop_i == EXE_MULTU_OP) begin
        hl = exp_mul(aluop_i == EXE_MULT_OP, reg1_i, reg2_i);
        {e_hi, e_lo} = hl;
        e_whilo = 1'b1;
      end else if ((aluop_i == EXE_DIV_OP || aluop_i == EXE_DIVU_OP) && !flush_i) begin
        if (div_left == 1) begin
          hl = exp_div(aluop_i == EXE_DIV_OP, reg1_i, reg2_i);
          {e_hi, e_lo} = hl;
          e_whilo = 1'b1;
        end else begin
          e_stall = 1'b1;
        end
      end
    end
    check("cyc_wd",    64'(wd_o),       64'(e_wd));
    check("cyc_wreg",  64'(wreg_o),     64'(e_wreg));
    check("cyc_wdata", 64'(wdata_o),    64'(e_wdata));
    check("cyc_hi",    64'(hi_o),       64'(e_hi));
    check("cyc_lo",    64'(lo_o),       64'(e_lo));
    check("cyc_whilo", 64'(whilo_o),    64'(e_whilo));
    check("cyc_stall", 64'(stallreq_o), 64'(e_stall));
  end

  task automatic set_in(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wd, input logic wreg);
    aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = wreg;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Issues a divide and holds it until the result cycle has been seen (bounded)
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int stalls, output int wh, output logic [31:0] hi, output logic [31:0] lo);
    set_in(sgn ? EXE_DIV_OP : EXE_DIVU_OP, EXE_RES_NOP, a, b, 5'd0, 1'b0);
    stalls = 0; wh = 0; hi = 32'h0; lo = 32'h0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (stallreq_o) stalls++;
      if (whilo_o) begin
        wh++;
        hi = hi_o;
        lo = lo_o;
      end
      next_cyc();
      if (wh != 0) break;
    end
    set_in(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 300));
      default: return $urandom;
    endcase
  endfunction

  task automatic abort_div(input bit by_reset);
    int wh;
    set_in(EXE_DIV_OP, EXE_RES_NOP, 32'd100, 32'd7, 5'd0, 1'b0);
    repeat (11) next_cyc();
    if (by_reset) rst = 1'b0; else flush_i = 1'b1;
    @(negedge clk);
    check(by_reset ? "rst_abort_stall" : "flush_stall", 64'(stallreq_o), 64'(0));
    check(by_reset ? "rst_abort_whilo" : "flush_whilo", 64'(whilo_o), 64'(0));
    next_cyc();
    rst = 1'b1; flush_i = 1'b0;
    set_in(EXE_ADD_OP, EXE_RES_ARITH, 32'd1, 32'd2, 5'd9, 1'b1);
    wh = 0;
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("abort_add_wdata", 64'(wdata_o), 64'(3));
        check("abort_add_stall", 64'(stallreq_o), 64'(0));
      end
      if (whilo_o) wh++;
      next_cyc();
    end
    check("abort_no_whilo", 64'(wh), 64'(0));
  endtask

  logic [7:0] alu_ops  [13];
  logic [2:0] alu_sels [13];

  initial begin
    int stalls, wh, idx, kind;
    logic [31:0] hi, lo, a, b;

    alu_ops  = '{EXE_OR_OP, EXE_AND_OP, EXE_XOR_OP, EXE_NOT_OP, EXE_SHL_OP, EXE_SHR_OP, EXE_SAR_OP,
                 EXE_MOV_OP, EXE_MOVZ_OP, EXE_MOVN_OP, EXE_ADD_OP, EXE_SUB_OP, EXE_NOP_OP};
    alu_sels = '{EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_SHIFT,
                 EXE_RES_SHIFT, EXE_RES_SHIFT, EXE_RES_MOVE, EXE_RES_MOVE, EXE_RES_MOVE,
                 EXE_RES_ARITH, EXE_RES_ARITH, EXE_RES_NOP};

    // Reset: non-trivial inputs, outputs must still be zero
    set_in(EXE_MULT_OP, EXE_RES_LOGIC, 32'h1234_5678, 32'h2, 5'd3, 1'b1);
    repeat (3) next_cyc();
    @(negedge clk);
    check("reset_wdata", 64'(wdata_o), 64'(0));
    check("reset_wreg",  64'(wreg_o),  64'(0));
    check("reset_whilo", 64'(whilo_o), 64'(0));
    check("reset_hi",    64'(hi_o),    64'(0));
    next_cyc();
    rst = 1'b1;

    set_in(EXE_OR_OP, EXE_RES_LOGIC, 32'hF0F0_0000, 32'h0000_0F0F, 5'd3, 1'b1);
    @(negedge clk);
    check("or_wdata", 64'(wdata_o), 64'(32'hF0F0_0F0F));
    check("or_wd",    64'(wd_o),    64'(3));
    check("or_wreg",  64'(wreg_o),  64'(1));
    check("or_stall", 64'(stallreq_o), 64'(0));
    next_cyc();

    set_in(EXE_SAR_OP, EXE_RES_SHIFT, 32'h8000_0000, 32'd4, 5'd4, 1'b1);
    @(negedge clk);
    check("sar_wdata", 64'(wdata_o), 64'(32'hF800_0000));
    next_cyc();
    set_in(EXE_SHR_OP, EXE_RES_SHIFT, 32'h8000_0000, 32'd4, 5'd4, 1'b1);
    @(negedge clk);
    check("shr_wdata", 64'(wdata_o), 64'(32'h0800_0000));
    next_cyc();

    set_in(EXE_MULT_OP, EXE_RES_NOP, 32'hFFFF_FFFF, 32'd2, 5'd0, 1'b0);
    @(negedge clk);
    check("mult_hi",    64'(hi_o),    64'(32'hFFFF_FFFF));
    check("mult_lo",    64'(lo_o),    64'(32'hFFFF_FFFE));
    check("mult_whilo", 64'(whilo_o), 64'(1));
    next_cyc();
    set_in(EXE_MULTU_OP, EXE_RES_NOP, 32'hFFFF_FFFF, 32'd2, 5'd0, 1'b0);
    @(negedge clk);
    check("multu_hi", 64'(hi_o), 64'(1));
    check("multu_lo", 64'(lo_o), 64'(32'hFFFF_FFFE));
    next_cyc();

    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, stalls, wh, hi, lo);
    check("div_stalls", 64'(stalls), 64'(33));
    check("div_whilo",  64'(wh),     64'(1));
    check("div_lo",     64'(lo),     64'(32'hFFFF_FFFD));
    check("div_hi",     64'(hi),     64'(32'hFFFF_FFFF));
    @(negedge clk);
    check("div_whilo_once", 64'(whilo_o), 64'(0));
    next_cyc();

    run_div(1'b0, 32'd5, 32'd0, stalls, wh, hi, lo);
    check("divz_stalls", 64'(stalls), 64'(2));
    check("divz_lo",     64'(lo),     64'(32'hFFFF_FFFF));
    check("divz_hi",     64'(hi),     64'(5));

    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, stalls, wh, hi, lo);
    check("divmin_lo", 64'(lo), 64'(32'h8000_0000));
    check("divmin_hi", 64'(hi), 64'(0));

    abort_div(1'b0);
    abort_div(1'b1);

    // Random mix of single-cycle operations and divides
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      a = pick_val();
      b = pick_val();
      if (kind <= 6) begin
        idx = $urandom_range(0, 12);
        set_in(alu_ops[idx], ($urandom_range(0, 15) == 0) ? 3'd7 : alu_sels[idx], a,
               ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : b,
               5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        next_cyc();
      end else if (kind == 7) begin
        set_in(($urandom_range(0, 1) == 0) ? EXE_MULT_OP : EXE_MULTU_OP, EXE_RES_NOP, a, b,
               5'($urandom_range(0, 31)), 1'b0);
        next_cyc();
      end else begin
        if ($urandom_range(0, 3) == 0) b = 32'h0;
        run_div(1'($urandom_range(0, 1)), a, b, stalls, wh, hi, lo);
        check("rnd_div_stalls", 64'(stalls), 64'((b == 32'h0) ? 2 : 33));
        check("rnd_div_whilo",  64'(wh),     64'(1));
      end
    end

    set_in(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    next_cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
